io_controller_debug_jtag_host: RTL and testbench

IO_CONTROLLER_DEBUG_JTAG_HOST -- requirements
Module: io_controller_debug_jtag_host

---
 rtl/io_controller_debug_jtag_host.sv | 195 +++++++++++++++++++
 tb/tb_io_controller_debug_jtag_host.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_controller_debug_jtag_host.sv
// JTAG debug host: runs one virtual-JTAG transaction per accepted command.
// The IR value is latched, then the host walks UIR -> CDR -> SDR -> E1DR and
// shifts DR_WIDTH bits LSB first, capturing tdo into a response register.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (cmd_ir, cmd_data)
//   tck, tdi, tdo              generated JTAG clock and serial data
//   ir_in, vs_*                latched virtual IR and virtual state strobes
//   jtag_state_rti             high while idle or holding a response
//   rsp_valid/rsp_ready        response handshake (rsp_data)
module io_controller_debug_jtag_host #(
    parameter int unsigned DR_WIDTH = 38,
    parameter int unsigned TCK_HALF = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    input  logic                tdo,
    output logic                tck,
    output logic                tdi,
    output logic [1:0]          ir_in,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_e1dr,
    output logic                jtag_state_rti,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data
);

    localparam int unsigned DIV_W = 8;
    localparam int unsigned CNT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_UIR  = 3'd1;
    localparam logic [2:0] S_CDR  = 3'd2;
    localparam logic [2:0] S_SDR  = 3'd3;
    localparam logic [2:0] S_E1DR = 3'd4;
    localparam logic [2:0] S_RSP  = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                tck_q, tck_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DR_WIDTH-1:0] tx_q, tx_d;
    logic [DR_WIDTH-1:0] rx_q, rx_d;
    logic [1:0]          ir_q, ir_d;
    logic                tdi_q, tdi_d;
    logic                vs_uir_q, vs_uir_d;
    logic                vs_cdr_q, vs_cdr_d;
    logic                vs_sdr_q, vs_sdr_d;
    logic                vs_e1dr_q, vs_e1dr_d;
    logic                rti_q, rti_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;

    logic                active;
    logic                toggle;
    logic                rise;
    logic                fall;

    // Next-state, tck divider, shift registers and registered output decode
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        tck_d     = tck_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        ir_d      = ir_q;

        active = (state_q == S_UIR) || (state_q == S_CDR) ||
                 (state_q == S_SDR) || (state_q == S_E1DR);
        toggle = active && (div_q == DIV_W'(TCK_HALF - 1));
        rise   = toggle && !tck_q;
        fall   = toggle && tck_q;

        // tck only runs inside the scan states; idle/response park it low
        if (active) begin
            if (toggle) begin
                div_d = '0;
                tck_d = ~tck_q;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end else begin
            div_d = '0;
            tck_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_UIR;
                    ir_d    = cmd_ir;
                    tx_d    = cmd_data;
                end
            end
            S_UIR: begin
                if (fall) state_d = S_CDR;
            end
            S_CDR: begin
                if (fall) begin
                    state_d   = S_SDR;
                    bit_cnt_d = '0;
                end
            end
            S_SDR: begin
                // First sampled bit ends up in bit 0 after DR_WIDTH shifts
                if (rise) rx_d = {tdo, rx_q[DR_WIDTH-1:1]};
                if (fall) begin
                    tx_d = tx_q >> 1;
                    if (bit_cnt_q == CNT_W'(DR_WIDTH - 1)) begin
                        state_d   = S_E1DR;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_E1DR: begin
                if (fall) state_d = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step
        tdi_d       = (state_d == S_SDR) ? tx_d[0] : 1'b0;
        vs_uir_d    = (state_d == S_UIR);
        vs_cdr_d    = (state_d == S_CDR);
        vs_sdr_d    = (state_d == S_SDR);
        vs_e1dr_d   = (state_d == S_E1DR);
        rti_d       = (state_d == S_IDLE) || (state_d == S_RSP);
        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RSP);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            tck_q       <= 1'b0;
            bit_cnt_q   <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            ir_q        <= '0;
            tdi_q       <= 1'b0;
            vs_uir_q    <= 1'b0;
            vs_cdr_q    <= 1'b0;
            vs_sdr_q    <= 1'b0;
            vs_e1dr_q   <= 1'b0;
            rti_q       <= 1'b1;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            tck_q       <= tck_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            ir_q        <= ir_d;
            tdi_q       <= tdi_d;
            vs_uir_q    <= vs_uir_d;
            vs_cdr_q    <= vs_cdr_d;
            vs_sdr_q    <= vs_sdr_d;
            vs_e1dr_q   <= vs_e1dr_d;
            rti_q       <= rti_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign tck            = tck_q;
    assign tdi            = tdi_q;
    assign ir_in          = ir_q;
    assign vs_uir         = vs_uir_q;
    assign vs_cdr         = vs_cdr_q;
    assign vs_sdr         = vs_sdr_q;
    assign vs_e1dr        = vs_e1dr_q;
    assign jtag_state_rti = rti_q;
    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    // rx only moves during SDR, so it is stable for the whole response phase
    assign rsp_data       = rx_q;

endmodule

// File: tb/tb_io_controller_debug_jtag_host.sv
// Bench for io_controller_debug_jtag_host: a cycle-indexed transaction model
// predicts every control output each cycle; directed tests pin latency,
// captured data, strobe counts, reset behaviour and the TCK_HALF=1 variant.
module tb_io_controller_debug_jtag_host;

    localparam int W   = 38;
    localparam int H   = 2;
    localparam int P   = 2 * H;
    localparam int LAT = (W + 3) * P;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_ir;
    logic [W-1:0]  cmd_data;
    logic          tdo, tck, tdi;
    logic [1:0]    ir_in;
    logic          vs_uir, vs_cdr, vs_sdr, vs_e1dr, jtag_state_rti;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          tdo_ones;

    logic          b_cmd_valid, b_cmd_ready;
    logic [1:0]    b_cmd_ir;
    logic [W-1:0]  b_cmd_data;
    logic          b_tdo, b_tck, b_tdi;
    logic [1:0]    b_ir_in;
    logic          b_vs_uir, b_vs_cdr, b_vs_sdr, b_vs_e1dr, b_rti;
    logic          b_rsp_valid, b_rsp_ready;
    logic [W-1:0]  b_rsp_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Loopback slave unless forced to return ones
    assign tdo   = tdo_ones ? 1'b1 : tdi;
    assign b_tdo = b_tdi;

    io_controller_debug_jtag_host #(.DR_WIDTH(W), .TCK_HALF(H)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .tdo(tdo), .tck(tck), .tdi(tdi), .ir_in(ir_in),
        .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_e1dr(vs_e1dr),
        .jtag_state_rti(jtag_state_rti),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
    );

    io_controller_debug_jtag_host #(.DR_WIDTH(W), .TCK_HALF(1)) dut_b (
        .clk(clk), .reset(reset),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_ir(b_cmd_ir), .cmd_data(b_cmd_data),
        .tdo(b_tdo), .tck(b_tck), .tdi(b_tdi), .ir_in(b_ir_in),
        .vs_uir(b_vs_uir), .vs_cdr(b_vs_cdr), .vs_sdr(b_vs_sdr), .vs_e1dr(b_vs_e1dr),
        .jtag_state_rti(b_rti),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction model: m_t counts clk cycles since the first UIR cycle
    bit           m_busy = 1'b0;
    int           m_t    = 0;
    logic [W-1:0] m_data = '0;
    logic [1:0]   m_ir   = '0;
    bit           m_ones = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_t    <= 0;
            m_ir   <= 2'b00;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy <= 1'b1;
                m_t    <= 0;
                m_data <= cmd_data;
                m_ir   <= cmd_ir;
                m_ones <= tdo_ones;
            end
        end else if (m_t >= LAT && rsp_ready) begin
            m_busy <= 1'b0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    // Compare process: phase 0 idle, 1 UIR, 2 CDR, 3 SDR, 4 E1DR, 5 RSP
    int          cnt_uir = 0, cnt_cdr = 0, cnt_sdr = 0, cnt_e1dr = 0;
    logic        prev_tck = 1'b0;
    logic [3:0]  prev_vs  = 4'b0;

    always @(negedge clk) begin
        int          k, ph, idx;
        logic        e_tck, e_tdi;
        logic [10:0] e_ctl, a_ctl;
        logic [3:0]  cur_vs;
        k = m_t / P;
        if (!m_busy)        ph = 0;
        else if (k == 0)    ph = 1;
        else if (k == 1)    ph = 2;
        else if (k <= W + 1) ph = 3;
        else if (k == W + 2) ph = 4;
        else                ph = 5;
        e_tck = (ph >= 1 && ph <= 4) && ((m_t % P) >= H);
        e_tdi = 1'b0;
        if (ph == 3) begin
            idx   = k - 2;
            e_tdi = m_data[idx];
        end
        e_ctl = {e_tck, e_tdi, ph == 1, ph == 2, ph == 3, ph == 4,
                 (ph == 0) || (ph == 5), ph == 0, ph == 5, m_ir};
        a_ctl = {tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_e1dr,
                 jtag_state_rti, cmd_ready, rsp_valid, ir_in};
        chk("ctrl{tck,tdi,uir,cdr,sdr,e1dr,rti,rdy,rvld,ir}", 64'(a_ctl), 64'(e_ctl));
        if (ph == 5)
            chk("rsp_data", 64'(rsp_data), m_ones ? 64'(38'h3F_FFFF_FFFF) : 64'(m_data));

        cur_vs = {vs_uir, vs_cdr, vs_sdr, vs_e1dr};
        if (!reset && prev_vs != 4'b0 && cur_vs != prev_vs)
            chk("strobe_change_on_tck_fall", 64'({prev_tck, tck}), 64'(2'b10));
        if (!m_busy) begin
            cnt_uir = 0; cnt_cdr = 0; cnt_sdr = 0; cnt_e1dr = 0;
        end else if (!prev_tck && tck) begin
            if (vs_uir)  cnt_uir++;
            if (vs_cdr)  cnt_cdr++;
            if (vs_sdr)  cnt_sdr++;
            if (vs_e1dr) cnt_e1dr++;
        end
        prev_tck = tck;
        prev_vs  = cur_vs;
    end

    // Wait for rsp_valid counting from the first UIR cycle
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Caller is at a negedge; the command is offered immediately
    task automatic run_txn(input string tag, input logic [1:0] ir, input logic [W-1:0] data,
                           input bit ones, input bit hold_ready,
                           input logic [W-1:0] exp_rsp, input logic [1:0] exp_ir);
        int lat;
        cmd_valid = 1'b1;
        cmd_ir    = ir;
        cmd_data  = data;
        tdo_ones  = ones;
        rsp_ready = hold_ready;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp(lat);
        chk({tag, "_latency"}, 64'(lat), 64'd164);
        chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp_rsp));
        chk({tag, "_ir_in"}, 64'(ir_in), 64'(exp_ir));
        chk({tag, "_sdr_rises"}, 64'(cnt_sdr), 64'd38);
        chk({tag, "_uir_cdr_e1dr_rises"}, 64'({8'(cnt_uir), 8'(cnt_cdr), 8'(cnt_e1dr)}), 64'(24'h010101));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        tdo_ones  = 1'b0;
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        int lat, guard;
        logic [W-1:0] snap;
        reset = 1'b1; cmd_valid = 1'b0; cmd_ir = 2'b00; cmd_data = '0;
        rsp_ready = 1'b0; tdo_ones = 1'b0;
        b_cmd_valid = 1'b0; b_cmd_ir = 2'b00; b_cmd_data = '0; b_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs{tck,tdi,vs,rti,rdy,rvld,ir}",
            64'({tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_e1dr, jtag_state_rti, cmd_ready, rsp_valid, ir_in}),
            64'(11'b00_0000_110_00));
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);

        // Release reset and offer the first command on the same cycle
        reset = 1'b0;
        run_txn("loop1", 2'b01, 38'h2A_5A5A_5A5A, 1'b0, 1'b0, 38'h2A_5A5A_5A5A, 2'b01);
        run_txn("ones", 2'b10, 38'h0, 1'b1, 1'b1, 38'h3F_FFFF_FFFF, 2'b10);
        run_txn("loop2", 2'b11, 38'h15_A5A5_1234, 1'b0, 1'b0, 38'h15_A5A5_1234, 2'b11);

        // Reset in the middle of SDR bit 17 while tck is high
        cmd_valid = 1'b1; cmd_ir = 2'b01; cmd_data = 38'h3C_0F0F_F0F0;
        @(negedge clk);
        cmd_valid = 1'b0;
        guard = 0;
        while (m_t != (2 + 17) * P + H && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_sdr_bit17", 64'(guard < 1000), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("midsdr_reset{tck,sdr,rdy,rvld,rti}",
            64'({tck, vs_sdr, cmd_ready, rsp_valid, jtag_state_rti}), 64'(5'b00101));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        run_txn("after_rst", 2'b10, 38'h01_2345_6789, 1'b0, 1'b0, 38'h01_2345_6789, 2'b10);

        // Response held off with cmd_valid asserted the whole time
        cmd_valid = 1'b1; cmd_ir = 2'b01; cmd_data = 38'h0A_BCDE_F012;
        @(negedge clk);
        wait_rsp(lat);
        chk("hold_latency", 64'(lat), 64'd164);
        snap = rsp_data;
        cmd_ir = 2'b11; cmd_data = 38'h35_4321_0FED;
        repeat (20) begin
            @(negedge clk);
            chk("hold_rsp_stable", 64'(rsp_data), 64'(38'h0A_BCDE_F012));
            chk("hold_no_accept", 64'({cmd_ready, rsp_valid}), 64'(2'b01));
        end
        chk("hold_snapshot", 64'(snap), 64'(38'h0A_BCDE_F012));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_handshake_idle{rdy,uir,ir}", 64'({cmd_ready, vs_uir, ir_in}), 64'(4'b1001));
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("second_started{rdy,uir,ir}", 64'({cmd_ready, vs_uir, ir_in}), 64'(4'b0111));
        wait_rsp(lat);
        chk("second_latency", 64'(lat), 64'd164);
        chk("second_rsp_data", 64'(rsp_data), 64'(38'h35_4321_0FED));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // TCK_HALF = 1 instance: tck period of two clk cycles
        b_cmd_valid = 1'b1; b_cmd_ir = 2'b01; b_cmd_data = 38'h0F_0F0F_3C3C;
        @(negedge clk);
        b_cmd_valid = 1'b0;
        lat = 0;
        while (!b_rsp_valid && lat < 1000) begin
            if (lat < 82) chk("b_tck_phase", 64'(b_tck), 64'(lat % 2));
            @(negedge clk);
            lat++;
        end
        chk("b_latency", 64'(lat), 64'd82);
        chk("b_rsp_data", 64'(b_rsp_data), 64'(38'h0F_0F0F_3C3C));
        chk("b_ir_in", 64'(b_ir_in), 64'd1);
        b_rsp_ready = 1'b1;
        @(negedge clk);
        b_rsp_ready = 1'b0;
        chk("b_idle_after", 64'({b_cmd_ready, b_rsp_valid, b_tck}), 64'(3'b100));

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
